// File: rtl/rv_pkg.sv
// Shared RV integer-core definitions: load funct3 encodings, widths and the
// load-queue entry layout used by the writeback stage.
package rv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    localparam logic [2:0] LOAD_F3_LB  = 3'b000;
    localparam logic [2:0] LOAD_F3_LH  = 3'b001;
    localparam logic [2:0] LOAD_F3_LW  = 3'b010;
    localparam logic [2:0] LOAD_F3_LBU = 3'b100;
    localparam logic [2:0] LOAD_F3_LHU = 3'b101;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [2:0]            funct3;
        logic [1:0]            off;
    } ldq_entry_t;

endpackage

// File: rtl/rv_load_align.sv
// Combinational load data alignment: selects the addressed byte/half of a raw
// memory word and sign- or zero-extends it to XLEN. Shared with the LSU.
module rv_load_align
    import rv_pkg::*;
#(
    parameter int XLEN = rv_pkg::XLEN
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      off,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] result
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // off[0] is ignored for halfwords; no misalignment trap is raised here.
    assign byte_sel = word[{off, 3'b000} +: 8];
    assign half_sel = word[{off[1], 4'b0000} +: 16];

    always_comb begin
        result = word;
        case (funct3)
            LOAD_F3_LB:  result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
            LOAD_F3_LBU: result = {{(XLEN-8){1'b0}}, byte_sel};
            LOAD_F3_LH:  result = {{(XLEN-16){half_sel[15]}}, half_sel};
            LOAD_F3_LHU: result = {{(XLEN-16){1'b0}}, half_sel};
            default:     result = word;
        endcase
    end

endmodule

// File: rtl/rf_writeback.sv
// Regfile write-port producer: arbitrates load responses over ALU results,
// tracks outstanding loads in order and exports a pending-destination mask.
module rf_writeback
    import rv_pkg::*;
#(
    parameter int XLEN      = rv_pkg::XLEN,
    parameter int LDQ_DEPTH = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          alu_valid,
    output logic                          alu_ready,
    input  logic [REG_ADDR_W-1:0]         alu_rd,
    input  logic [XLEN-1:0]               alu_result,
    input  logic                          ld_issue_valid,
    output logic                          ld_issue_ready,
    input  logic [REG_ADDR_W-1:0]         ld_issue_rd,
    input  logic [2:0]                    ld_issue_funct3,
    input  logic [1:0]                    ld_issue_off,
    input  logic                          mem_rvalid,
    input  logic [XLEN-1:0]               mem_rdata,
    output logic                          rf_we,
    output logic [REG_ADDR_W-1:0]         rf_wa,
    output logic [XLEN-1:0]               rf_wdata,
    output logic [31:0]                   busy_mask,
    output logic [$clog2(LDQ_DEPTH):0]    ldq_count,
    output logic                          err_unexpected
);

    localparam int PTR_W = $clog2(LDQ_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(LDQ_DEPTH);

    ldq_entry_t            ldq_mem_reg [LDQ_DEPTH];
    logic [LDQ_DEPTH-1:0]  ldq_valid_reg, ldq_valid_next;
    logic [PTR_W-1:0]      rd_ptr_reg, wr_ptr_reg;
    logic [CNT_W-1:0]      count_reg, count_next;
    logic                  err_reg;

    logic                  rf_we_reg, rf_we_next;
    logic [REG_ADDR_W-1:0] rf_wa_reg, rf_wa_next;
    logic [XLEN-1:0]       rf_wdata_reg, rf_wdata_next;

    ldq_entry_t            head;
    logic [XLEN-1:0]       load_data;
    logic                  push, pop, alu_accept, stray_rsp;
    logic [31:0]           entry_onehot [LDQ_DEPTH];
    logic [31:0]           busy_all;

    assign head = ldq_mem_reg[rd_ptr_reg];

    // Load responses cannot be backpressured, so they always win the port.
    assign alu_ready      = reset & ~mem_rvalid;
    assign ld_issue_ready = reset & (count_reg < DEPTH_CNT);
    assign alu_accept     = alu_valid & alu_ready;
    assign push           = ld_issue_valid & ld_issue_ready;
    assign pop            = reset & mem_rvalid & (count_reg != '0);
    assign stray_rsp      = reset & mem_rvalid & (count_reg == '0);

    rv_load_align #(.XLEN(XLEN)) u_align (
        .funct3 (head.funct3),
        .off    (head.off),
        .word   (mem_rdata),
        .result (load_data)
    );

    genvar gi;
    generate
        for (gi = 0; gi < LDQ_DEPTH; gi++) begin : g_entry
            assign ldq_valid_next[gi] =
                ~reset                                   ? 1'b0 :
                (push && wr_ptr_reg == PTR_W'(gi))       ? 1'b1 :
                (pop  && rd_ptr_reg == PTR_W'(gi))       ? 1'b0 :
                                                           ldq_valid_reg[gi];
            assign entry_onehot[gi] = ldq_valid_reg[gi] ?
                (32'd1 << ldq_mem_reg[gi].rd) : 32'd0;
        end
    endgenerate

    always_comb begin
        busy_all = '0;
        for (int i = 0; i < LDQ_DEPTH; i++) begin
            busy_all = busy_all | entry_onehot[i];
        end
        busy_mask = {busy_all[31:1], 1'b0};
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // x0 destinations still consume the event but never assert the write enable.
    always_comb begin
        rf_we_next    = 1'b0;
        rf_wa_next    = rf_wa_reg;
        rf_wdata_next = rf_wdata_reg;
        if (pop) begin
            rf_we_next    = (head.rd != '0);
            rf_wa_next    = head.rd;
            rf_wdata_next = load_data;
        end else if (alu_accept) begin
            rf_we_next    = (alu_rd != '0);
            rf_wa_next    = alu_rd;
            rf_wdata_next = alu_result;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            ldq_mem_reg[wr_ptr_reg] <= '{rd: ld_issue_rd, funct3: ld_issue_funct3, off: ld_issue_off};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ldq_valid_reg <= '0;
            rd_ptr_reg    <= '0;
            wr_ptr_reg    <= '0;
            count_reg     <= '0;
            err_reg       <= 1'b0;
            rf_we_reg     <= 1'b0;
            rf_wa_reg     <= '0;
            rf_wdata_reg  <= '0;
        end else begin
            ldq_valid_reg <= ldq_valid_next;
            count_reg     <= count_next;
            err_reg       <= err_reg | stray_rsp;
            rf_we_reg     <= rf_we_next;
            rf_wa_reg     <= rf_wa_next;
            rf_wdata_reg  <= rf_wdata_next;
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
        end
    end

    assign rf_we          = rf_we_reg;
    assign rf_wa          = rf_wa_reg;
    assign rf_wdata       = rf_wdata_reg;
    assign ldq_count      = count_reg;
    assign err_unexpected = err_reg;

endmodule

// File: tb/tb_rf_writeback.sv
// Directed bench for rf_writeback: hand-computed vectors for reset, ALU path,
// load alignment, arbitration, queue wrap and stray responses.
module tb_rf_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        alu_valid;
    logic        alu_ready;
    logic [4:0]  alu_rd;
    logic [31:0] alu_result;
    logic        ld_issue_valid;
    logic        ld_issue_ready;
    logic [4:0]  ld_issue_rd;
    logic [2:0]  ld_issue_funct3;
    logic [1:0]  ld_issue_off;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
    logic        rf_we;
    logic [4:0]  rf_wa;
    logic [31:0] rf_wdata;
    logic [31:0] busy_mask;
    logic [1:0]  ldq_count;
    logic        err_unexpected;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rf_writeback dut (
        .clk             (clk),
        .reset           (reset),
        .alu_valid       (alu_valid),
        .alu_ready       (alu_ready),
        .alu_rd          (alu_rd),
        .alu_result      (alu_result),
        .ld_issue_valid  (ld_issue_valid),
        .ld_issue_ready  (ld_issue_ready),
        .ld_issue_rd     (ld_issue_rd),
        .ld_issue_funct3 (ld_issue_funct3),
        .ld_issue_off    (ld_issue_off),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata),
        .rf_we           (rf_we),
        .rf_wa           (rf_wa),
        .rf_wdata        (rf_wdata),
        .busy_mask       (busy_mask),
        .ldq_count       (ldq_count),
        .err_unexpected  (err_unexpected)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end else begin
            $display("ok   %s got=0x%08h", tag, got);
        end
    endtask

    // Advance one clock; registered outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        alu_valid       = 1'b0;
        alu_rd          = '0;
        alu_result      = '0;
        ld_issue_valid  = 1'b0;
        ld_issue_rd     = '0;
        ld_issue_funct3 = '0;
        ld_issue_off    = '0;
        mem_rvalid      = 1'b0;
        mem_rdata       = '0;
    endtask

    task automatic issue(input logic [4:0] rd, input logic [2:0] f3, input logic [1:0] off);
        ld_issue_valid  = 1'b1;
        ld_issue_rd     = rd;
        ld_issue_funct3 = f3;
        ld_issue_off    = off;
    endtask

    // Six-load wrap sequence: rd, funct3, offset, memory word, expected write data.
    logic [4:0]  w_rd  [6] = '{5'd11, 5'd12, 5'd13, 5'd14, 5'd15, 5'd0};
    logic [2:0]  w_f3  [6] = '{3'b000, 3'b001, 3'b110, 3'b100, 3'b101, 3'b000};
    logic [1:0]  w_off [6] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2};
    logic [31:0] w_word[6] = '{32'h1122_7F44, 32'hF00D_0001, 32'hA5A5_5A5A,
                               32'h0000_00FE, 32'h1234_9ABC, 32'h0080_0000};
    logic [31:0] w_exp [6] = '{32'h0000_007F, 32'hFFFF_F00D, 32'hA5A5_5A5A,
                               32'h0000_00FE, 32'h0000_9ABC, 32'hFFFF_FF80};

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] exp_busy;
        idle_inputs();
        reset      = 1'b0;
        alu_valid  = 1'b1;
        alu_rd     = 5'd5;
        alu_result = 32'h1;

        // Reset held for three cycles with an ALU result offered.
        for (int i = 0; i < 3; i++) begin
            step();
            check("rst_alu_ready", {31'd0, alu_ready}, 32'd0);
            check("rst_rf_we", {31'd0, rf_we}, 32'd0);
            check("rst_busy", busy_mask, 32'd0);
        end
        check("rst_ld_ready", {31'd0, ld_issue_ready}, 32'd0);
        check("rst_count", {30'd0, ldq_count}, 32'd0);
        check("rst_err", {31'd0, err_unexpected}, 32'd0);
        check("rst_wdata", rf_wdata, 32'd0);

        // ALU write to x5, then to x0.
        reset      = 1'b1;
        alu_rd     = 5'd5;
        alu_result = 32'hDEAD_BEEF;
        settle();
        check("alu_ready", {31'd0, alu_ready}, 32'd1);
        step();
        check("alu_we", {31'd0, rf_we}, 32'd1);
        check("alu_wa", {27'd0, rf_wa}, 32'd5);
        check("alu_wdata", rf_wdata, 32'hDEAD_BEEF);
        alu_rd = 5'd0;
        settle();
        check("alu_x0_ready", {31'd0, alu_ready}, 32'd1);
        step();
        check("alu_x0_we", {31'd0, rf_we}, 32'd0);
        idle_inputs();
        step();
        check("idle_we", {31'd0, rf_we}, 32'd0);

        // LB x7 off3 and LHU x8 off2 with busy tracking.
        issue(5'd7, 3'b000, 2'd3);
        step();
        issue(5'd8, 3'b101, 2'd2);
        check("busy_x7", busy_mask, 32'h0000_0080);
        step();
        ld_issue_valid = 1'b0;
        settle();
        check("busy_x7_x8", busy_mask, 32'h0000_0180);
        check("full_count", {30'd0, ldq_count}, 32'd2);
        check("full_ld_ready", {31'd0, ld_issue_ready}, 32'd0);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h80FF_0000;
        settle();
        check("rsp_alu_ready", {31'd0, alu_ready}, 32'd0);
        step();
        check("lb_we", {31'd0, rf_we}, 32'd1);
        check("lb_wa", {27'd0, rf_wa}, 32'd7);
        check("lb_wdata", rf_wdata, 32'hFFFF_FF80);
        check("busy_after_lb", busy_mask, 32'h0000_0100);
        mem_rdata = 32'h8001_1234;
        step();
        check("lhu_wa", {27'd0, rf_wa}, 32'd8);
        check("lhu_wdata", rf_wdata, 32'h0000_8001);
        check("busy_empty", busy_mask, 32'd0);
        check("empty_count", {30'd0, ldq_count}, 32'd0);
        mem_rvalid = 1'b0;

        // Load response and ALU result in the same cycle.
        issue(5'd9, 3'b010, 2'd3);
        step();
        ld_issue_valid = 1'b0;
        mem_rvalid     = 1'b1;
        mem_rdata      = 32'h1234_5678;
        alu_valid      = 1'b1;
        alu_rd         = 5'd10;
        alu_result     = 32'hCAFE_0001;
        settle();
        check("arb_alu_ready", {31'd0, alu_ready}, 32'd0);
        step();
        check("arb_ld_wa", {27'd0, rf_wa}, 32'd9);
        check("arb_ld_wdata", rf_wdata, 32'h1234_5678);
        mem_rvalid = 1'b0;
        settle();
        check("arb_alu_ready2", {31'd0, alu_ready}, 32'd1);
        step();
        check("arb_alu_we", {31'd0, rf_we}, 32'd1);
        check("arb_alu_wa", {27'd0, rf_wa}, 32'd10);
        check("arb_alu_wdata", rf_wdata, 32'hCAFE_0001);
        idle_inputs();

        // Six loads through a two-entry queue, with pointer wrap.
        issue(w_rd[0], w_f3[0], w_off[0]);
        step();
        issue(w_rd[1], w_f3[1], w_off[1]);
        step();
        ld_issue_valid = 1'b0;
        for (int k = 0; k < 6; k++) begin
            mem_rvalid = 1'b1;
            mem_rdata  = w_word[k];
            if (k >= 1 && k <= 4) issue(w_rd[k+1], w_f3[k+1], w_off[k+1]);
            else ld_issue_valid = 1'b0;
            settle();
            check($sformatf("wrap%0d_ld_ready", k), {31'd0, ld_issue_ready}, (k >= 1) ? 32'd1 : 32'd0);
            exp_busy = (32'd1 << w_rd[k]) | ((k == 0) ? (32'd1 << w_rd[1]) : 32'd0);
            exp_busy[0] = 1'b0;
            check($sformatf("wrap%0d_busy", k), busy_mask, exp_busy);
            step();
            check($sformatf("wrap%0d_we", k), {31'd0, rf_we}, (w_rd[k] != 5'd0) ? 32'd1 : 32'd0);
            if (w_rd[k] != 5'd0) begin
                check($sformatf("wrap%0d_wa", k), {27'd0, rf_wa}, {27'd0, w_rd[k]});
                check($sformatf("wrap%0d_wdata", k), rf_wdata, w_exp[k]);
            end
            check($sformatf("wrap%0d_count", k), {30'd0, ldq_count}, (k == 5) ? 32'd0 : 32'd1);
        end
        idle_inputs();

        // Response with an empty queue sets the sticky error.
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h5555_5555;
        step();
        check("stray_err", {31'd0, err_unexpected}, 32'd1);
        check("stray_we", {31'd0, rf_we}, 32'd0);
        check("stray_count", {30'd0, ldq_count}, 32'd0);
        mem_rvalid = 1'b0;
        step();
        step();
        check("stray_sticky", {31'd0, err_unexpected}, 32'd1);
        reset = 1'b0;
        step();
        check("stray_cleared", {31'd0, err_unexpected}, 32'd0);

        // Reset flushes a pending load; its late response is a stray.
        reset = 1'b1;
        issue(5'd3, 3'b010, 2'd0);
        step();
        ld_issue_valid = 1'b0;
        settle();
        check("flush_busy_pre", busy_mask, 32'h0000_0008);
        reset = 1'b0;
        step();
        check("flush_count", {30'd0, ldq_count}, 32'd0);
        check("flush_busy", busy_mask, 32'd0);
        reset      = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h0BAD_F00D;
        step();
        check("flush_err", {31'd0, err_unexpected}, 32'd1);
        check("flush_we", {31'd0, rf_we}, 32'd0);
        idle_inputs();
        step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
